// File: rtl/rv_rand_instr_gen.sv
// rv_rand_instr_gen: reproducible LFSR-driven RV32I instruction source.
// Emits NOP_COUNT NOPs after reset, then ALU-imm / ALU-reg / LW / SW words
// derived from a 32-bit Galois LFSR over a valid/ready handshake, optionally
// stopping after MAX_INSTR words.
// Optional feature macro: STIM_HAZARD_AVOID_EN (scrubs sources that hit recent rd's).
module rv_rand_instr_gen #(
    parameter logic [31:0] SEED       = 32'h0000_01B4,
    parameter int unsigned NOP_COUNT  = 3,
    parameter int unsigned MAX_INSTR  = 0,
    parameter logic [3:0]  CLASS_MASK = 4'b1111,
    parameter int unsigned HAZ_WINDOW = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_bits,
    output logic [1:0]  instr_class,
    output logic [31:0] instr_count,
    output logic        done
);

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] TAPS     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    typedef enum logic [1:0] {S_NOP, S_GEN, S_DONE} state_e;

    if (CLASS_MASK == 4'b0000) begin : g_bad_mask
        $error("rv_rand_instr_gen: CLASS_MASK must enable at least one class");
    end
    if (HAZ_WINDOW == 0 || HAZ_WINDOW > 4) begin : g_bad_win
        $error("rv_rand_instr_gen: HAZ_WINDOW must be in 1..4");
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        return (r >> 1) ^ (r[0] ? TAPS : 32'h0);
    endfunction

    // A disabled class rolls forward to the next enabled one, wrapping at 3.
    function automatic logic [1:0] remap(input logic [1:0] c);
        logic [1:0] res;
        logic [1:0] cand;
        logic       hit;
        res = c;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = c + 2'(i);
            if (!hit && CLASS_MASK[cand]) begin
                res = cand;
                hit = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] r, input logic [1:0] c);
        logic [11:0] imm;
        logic [11:0] off;
        logic [6:0]  f7;
        logic [2:0]  f3;
        imm = r[11:0];
        f3  = r[19:17];
        // shift-immediates keep only shamt (and the arithmetic bit for SRAI)
        if (f3 == 3'd1)      imm = imm & 12'h01F;
        else if (f3 == 3'd5) imm = imm & 12'h41F;
        f7  = ((f3 == 3'd0 || f3 == 3'd5) && r[10]) ? 7'h20 : 7'h00;
        // word-aligned offset into a 16-word data memory
        off = {6'b0, r[5:2], 2'b00};
        case (c)
            2'd0:    return {imm, r[16:12], f3, r[24:20], 7'h13};
            2'd1:    return {f7, r[29:25], r[16:12], f3, r[24:20], 7'h33};
            2'd2:    return {off, 5'd0, 3'b010, r[24:20], 7'h03};
            default: return {off[11:5], r[29:25], 5'd0, 3'b010, off[4:0], 7'h23};
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [31:0] nop_cnt_q, nop_cnt_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic        valid_q, valid_d;
    logic [31:0] bits_q, bits_d;
    logic [1:0]  class_q, class_d;
    logic [31:0] count_q, count_d;
    logic        done_q, done_d;

    logic        hs, gen_hs, load;
    logic [31:0] lfsr_src, word_raw, word_src;
    logic [1:0]  cls_src;

    assign hs     = valid_q & instr_ready;
    assign gen_hs = hs && (state_q == S_GEN);
    // The next word is built from the LFSR as it will be after this cycle,
    // so a fresh word is ready the cycle right after a transfer.
    assign lfsr_src = gen_hs ? lfsr_step(lfsr_q) : lfsr_q;
    assign cls_src  = remap(lfsr_src[31:30]);
    assign word_raw = encode(lfsr_src, cls_src);

`ifdef STIM_HAZARD_AVOID_EN
    logic [HAZ_WINDOW-1:0][4:0] hist_q, hist_src;
    logic [4:0]                 rd_acc;

    // SW has no rd; every other class keeps rd in [11:7] (x0 never matches)
    assign rd_acc = (class_q != 2'd3) ? bits_q[11:7] : 5'd0;

    function automatic logic [31:0] scrub(input logic [31:0] w, input logic [1:0] c,
                                          input logic [HAZ_WINDOW-1:0][4:0] h);
        logic [31:0] o;
        o = w;
        for (int i = 0; i < HAZ_WINDOW; i++) begin
            if (h[i] != 5'd0) begin
                if ((c == 2'd0 || c == 2'd1) && w[19:15] == h[i]) o[19:15] = 5'd0;
                if ((c == 2'd1 || c == 2'd3) && w[24:20] == h[i]) o[24:20] = 5'd0;
            end
        end
        return o;
    endfunction

    // rd history as the next word sees it, including the word accepted now
    always_comb begin
        hist_src = hist_q;
        if (gen_hs) begin
            hist_src[0] = rd_acc;
            for (int i = 1; i < HAZ_WINDOW; i++) hist_src[i] = hist_q[i-1];
        end
    end

    // rd history register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hist_q <= '0;
        else          hist_q <= hist_src;
    end

    assign word_src = scrub(word_raw, cls_src, hist_src);
`else
    assign word_src = word_raw;
`endif

    // Next-state and output-register logic for NOP -> GEN -> DONE
    always_comb begin
        state_d   = state_q;
        nop_cnt_d = nop_cnt_q;
        lfsr_d    = lfsr_q;
        valid_d   = valid_q;
        bits_d    = bits_q;
        class_d   = class_q;
        count_d   = count_q;
        done_d    = done_q;
        load      = 1'b0;
        case (state_q)
            S_NOP: begin
                valid_d = 1'b1;
                bits_d  = NOP_WORD;
                class_d = 2'd0;
                if (NOP_COUNT == 0) begin
                    state_d = S_GEN;
                    load    = 1'b1;
                end else if (hs) begin
                    nop_cnt_d = nop_cnt_q + 32'd1;
                    if (nop_cnt_d == NOP_COUNT) begin
                        state_d = S_GEN;
                        load    = 1'b1;
                    end
                end
            end
            S_GEN: begin
                if (hs) begin
                    lfsr_d  = lfsr_src;
                    count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
                    if (MAX_INSTR != 0 && count_d == MAX_INSTR) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end else if (!valid_q) begin
                    load = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
        endcase
        // en only decides whether a new word is raised; a raised word holds
        if (load) begin
            valid_d = en;
            if (en) begin
                bits_d  = word_src;
                class_d = cls_src;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_NOP;
            nop_cnt_q <= '0;
            lfsr_q    <= SEED_EFF;
            valid_q   <= 1'b0;
            bits_q    <= NOP_WORD;
            class_q   <= 2'd0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            nop_cnt_q <= nop_cnt_d;
            lfsr_q    <= lfsr_d;
            valid_q   <= valid_d;
            bits_q    <= bits_d;
            class_q   <= class_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr_bits  = bits_q;
    assign instr_class = class_q;
    assign instr_count = count_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rv_rand_instr_gen.sv
// Directed bench for rv_rand_instr_gen: three instances (default, ALU-imm only,
// SEED=0 / no NOPs / MAX_INSTR=5) checked against hand-computed words.
module tb_rv_rand_instr_gen;

    logic clk = 1'b0;
    logic reset_n, en, rdy_a, rdy_b, rdy_c;
    logic va, vb, vc, da, db, dc;
    logic [31:0] ba, bb, bc, na, nb, nc;
    logic [1:0]  ca, cb, cc;

    int total = 0;
    int bad   = 0;

    // first 7 generated words from SEED 0x1B4 (LFSR 1B4, DA, 6D, 80200035, C0300019, E038000F, F03C0004)
    localparam logic [31:0] EXP_W [7] = '{32'h1B40_0013, 32'h0DA0_0013, 32'h06D0_0013,
                                          32'h0340_2103, 32'h0000_2C23, 32'h0100_2623,
                                          32'h0180_2223};
    localparam logic [1:0]  EXP_C [7] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3};
    localparam logic [31:0] W7 = 32'h01C0_70B3;   // LFSR 781E0002, ALU-reg
    localparam logic [31:0] W8 = 32'h0018_7013;   // LFSR 3C0F0001, ALU-imm

    always #5 clk = ~clk;

    rv_rand_instr_gen u_a (
        .clk(clk), .reset_n(reset_n), .en(en), .instr_valid(va), .instr_ready(rdy_a),
        .instr_bits(ba), .instr_class(ca), .instr_count(na), .done(da));

    rv_rand_instr_gen #(.CLASS_MASK(4'b0001)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en), .instr_valid(vb), .instr_ready(rdy_b),
        .instr_bits(bb), .instr_class(cb), .instr_count(nb), .done(db));

    rv_rand_instr_gen #(.SEED(32'h0), .NOP_COUNT(0), .MAX_INSTR(5)) u_c (
        .clk(clk), .reset_n(reset_n), .en(en), .instr_valid(vc), .instr_ready(rdy_c),
        .instr_bits(bc), .instr_class(cc), .instr_count(nc), .done(dc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 3 NOPs then the first 7 generated words on instance A, ready held high
    task automatic run_a(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_nop%0d_v", tag, i), va, 1);
            chk($sformatf("%s_nop%0d", tag, i), ba, 32'h13);
            step();
        end
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s_w%0d_v", tag, i), va, 1);
            chk($sformatf("%s_w%0d", tag, i), ba, EXP_W[i]);
            chk($sformatf("%s_c%0d", tag, i), ca, EXP_C[i]);
            step();
        end
    endtask

    logic [4:0] h0, h1, rs1, rs2;
    int hz, op_bad, s1_bad, s5_bad, cls_bad;

    initial begin
        reset_n = 1'b0; en = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        h0 = '0; h1 = '0; hz = 0; op_bad = 0; s1_bad = 0; s5_bad = 0; cls_bad = 0;

        // T1: reset values, NOP prologue, first generated words
        repeat (3) step();
        chk("rst_valid", va, 0);
        chk("rst_bits", ba, 32'h13);
        chk("rst_class", ca, 0);
        chk("rst_count", na, 0);
        chk("rst_done", da, 0);
        reset_n = 1'b1; rdy_a = 1'b1;
        step();
        run_a("t1");
        chk("t1_count", na, 7);

        // T5: async reset mid-stream, replay is identical
        reset_n = 1'b0;
        #1;
        chk("t5_async_valid", va, 0);
        chk("t5_async_bits", ba, 32'h13);
        chk("t5_async_count", na, 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        run_a("t5");
        chk("t5_count", na, 7);

        // T2: back-pressure holds the word even with en dropped
        chk("t2_w7", ba, W7);
        chk("t2_c7", ca, 1);
        rdy_a = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t2_hold%0d_v", i), va, 1);
            chk($sformatf("t2_hold%0d_bits", i), ba, W7);
            chk($sformatf("t2_hold%0d_cls", i), ca, 1);
            chk($sformatf("t2_hold%0d_cnt", i), na, 7);
        end
        rdy_a = 1'b1;
        step();
        chk("t2_count", na, 8);
        chk("t2_en_low_v", va, 0);
        en = 1'b1;
        step();
        chk("t2_w8_v", va, 1);
        chk("t2_w8", ba, W8);
        chk("t2_c8", ca, 0);

        // T6: scan 1000 accepted words for sources hitting the last 2 rd's
        for (int n = 0; n < 1000; n++) begin
            if (va) begin
                rs1 = ba[19:15];
                rs2 = ba[24:20];
                if ((ca == 2'd0 || ca == 2'd1) && rs1 != 0 && (rs1 == h0 || rs1 == h1)) hz++;
                if ((ca == 2'd1 || ca == 2'd3) && rs2 != 0 && (rs2 == h0 || rs2 == h1)) hz++;
                h1 = h0;
                h0 = (ca != 2'd3) ? ba[11:7] : 5'd0;
            end
            step();
        end
        chk("t6_count", na, 1008);
`ifdef STIM_HAZARD_AVOID_EN
        chk("t6_hazards", hz, 0);
`else
        chk("t6_hazards_seen", (hz > 0) ? 1 : 0, 1);
`endif

        // T3: ALU-imm only
        reset_n = 1'b0; rdy_a = 1'b0;
        repeat (2) step();
        reset_n = 1'b1; rdy_b = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_nop%0d", i), bb, 32'h13);
            step();
        end
        chk("t3_w0", bb, 32'h1B40_0013);
        repeat (3) step();
        chk("t3_w3_remap", bb, 32'h0350_0113);
        chk("t3_c3_remap", cb, 0);
        step();
        for (int n = 0; n < 300; n++) begin
            if (vb) begin
                if (bb[6:0] != 7'h13) op_bad++;
                if (bb[14:12] == 3'd1 && bb[31:25] != 7'h00) s1_bad++;
                if (bb[14:12] == 3'd5 && bb[31:25] != 7'h00 && bb[31:25] != 7'h20) s5_bad++;
                if (cb != 2'd0) cls_bad++;
            end
            step();
        end
        chk("t3_opcode", op_bad, 0);
        chk("t3_slli_imm", s1_bad, 0);
        chk("t3_srxi_imm", s5_bad, 0);
        chk("t3_class", cls_bad, 0);
        chk("t3_count", nb, 304);

        // T4: SEED=0 forced to 1, no NOPs, stop after 5 words
        reset_n = 1'b0; rdy_b = 1'b0;
        repeat (2) step();
        reset_n = 1'b1; rdy_c = 1'b1;
        step();
        chk("t4_w0_v", vc, 1);
        chk("t4_w0", bc, 32'h0010_0013);
        chk("t4_c0", cc, 0);
        step();
        chk("t4_w1", bc, 32'h0000_2103);
        chk("t4_c1", cc, 2);
        chk("t4_cnt1", nc, 1);
        repeat (3) step();
        chk("t4_cnt4", nc, 4);
        chk("t4_done4", dc, 0);
        chk("t4_v4", vc, 1);
        step();
        chk("t4_cnt5", nc, 5);
        chk("t4_done5", dc, 1);
        chk("t4_v5", vc, 0);
        repeat (3) step();
        chk("t4_hold_v", vc, 0);
        chk("t4_hold_cnt", nc, 5);
        chk("t4_hold_done", dc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
